// File: rtl/gb_cart_master.sv
// Game Boy cartridge-bus initiator.
// Turns valid/ready requests into timed cartridge read/write cycles. Each cycle runs through
// SETUP, STROBE and HOLD phases, and each phase lasts a parameterised number of clk cycles.
// Every pin is driven from a flop, so no req_* input reaches the cartridge combinationally.
module gb_cart_master #(
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned STROBE_CYC = 12,
    parameter int unsigned HOLD_CYC   = 4
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] address,
    inout  wire  [7:0]  data,
    output logic        nRD,
    output logic        nWR,
    output logic        nCS,
    output logic        OE
);

    localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    // The counter only ever holds (phase length - 1).
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             ready_q, ready_d;
    logic             nrd_q, nrd_d;
    logic             nwr_q, nwr_d;
    logic             ncs_q, ncs_d;
    logic             oe_q, oe_d;

    // Next-state logic: the phase FSM and the registered pin values for the coming cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        ready_d     = ready_q;
        nrd_d       = nrd_q;
        nwr_d       = nwr_q;
        ncs_d       = ncs_q;
        oe_d        = oe_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    ready_d = 1'b0;
                    // SRAM window 0xA000-0xBFFF
                    ncs_d   = ~(req_addr[15:13] == 3'b101);
                    oe_d    = req_write;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                    nrd_d   = write_q;
                    nwr_d   = ~write_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    nrd_d   = 1'b1;
                    nwr_d   = 1'b1;
                    // Sample while nRD is still low on this final strobe edge
                    if (!write_q) begin
                        rdata_d = data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    ncs_d       = 1'b1;
                    oe_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pin registers; reset releases the bus immediately
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            write_q     <= 1'b0;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            ncs_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            nrd_q       <= nrd_d;
            nwr_q       <= nwr_d;
            ncs_q       <= ncs_d;
            oe_q        <= oe_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign address   = addr_q;
    assign nRD       = nrd_q;
    assign nWR       = nwr_q;
    assign nCS       = ncs_q;
    assign OE        = oe_q;
    assign data      = oe_q ? wdata_q : 8'hzz;

endmodule
